// File: rtl/mdr_pkg.sv
// mdr_pkg: shared types and helpers for the handshaked memory data register.
//   state_e     - handshake FSM states
//   SZ_*        - access size encodings on the size port
//   MAX_WAIT_DEF- default wait-state limit (used only when MDR_TIMEOUT_EN is defined)
//   size_bytes  - number of bytes moved by an access of a given size
package mdr_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StWrWait
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_FULL = 2'b11;

  localparam int unsigned MAX_WAIT_DEF = 15;

  function automatic int unsigned size_bytes(input logic [1:0] sz, input int unsigned data_w);
    case (sz)
      SZ_BYTE: return 1;
      SZ_HALF: return 2;
      SZ_WORD: return 4;
      default: return data_w / 8;
    endcase
  endfunction

endpackage

// File: rtl/mdr_lane_align.sv
// mdr_lane_align: combinational lane steering for the memory data register.
//   Load side : i_mdatain shifted down by the latched byte offset, then sign/zero
//               extended from the latched size -> o_load_data.
//   Store side: low bytes of i_mdr replicated across every lane -> o_wdata.
//   Byte enables for a request being accepted (i_be_size/i_be_addr) -> o_be.
// Ports:
//   i_size, i_uns, i_addr   latched access attributes
//   i_mdatain, i_mdr        memory read data, current register contents
//   i_be_size, i_be_addr    attributes of the incoming request
//   o_load_data, o_wdata, o_be
module mdr_lane_align
  import mdr_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BE_W   = DATA_W / 8,
  parameter int unsigned AW     = $clog2(BE_W)
) (
  input  logic [1:0]        i_size,
  input  logic              i_uns,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_mdatain,
  input  logic [DATA_W-1:0] i_mdr,
  input  logic [1:0]        i_be_size,
  input  logic [AW-1:0]     i_be_addr,
  output logic [DATA_W-1:0] o_load_data,
  output logic [DATA_W-1:0] o_wdata,
  output logic [BE_W-1:0]   o_be
);

  localparam int unsigned NHalf = BE_W / 2;
  localparam int unsigned NWord = DATA_W / 32;

  logic [AW+2:0]     w_shamt;
  logic [DATA_W-1:0] w_shifted;
  logic [BE_W-1:0]   w_ones;
  int unsigned       w_nbytes;

  assign w_shamt   = {i_addr, 3'b000};
  assign w_shifted = i_mdatain >> w_shamt;

  always_comb begin
    o_load_data = w_shifted;
    case (i_size)
      SZ_BYTE: o_load_data = i_uns ? DATA_W'(w_shifted[7:0])
                                   : DATA_W'($signed(w_shifted[7:0]));
      SZ_HALF: o_load_data = i_uns ? DATA_W'(w_shifted[15:0])
                                   : DATA_W'($signed(w_shifted[15:0]));
      SZ_WORD: o_load_data = i_uns ? DATA_W'(w_shifted[31:0])
                                   : DATA_W'($signed(w_shifted[31:0]));
      default: o_load_data = w_shifted;
    endcase
  end

  always_comb begin
    o_wdata = i_mdr;
    case (i_size)
      SZ_BYTE: o_wdata = {BE_W{i_mdr[7:0]}};
      SZ_HALF: o_wdata = {NHalf{i_mdr[15:0]}};
      SZ_WORD: o_wdata = {NWord{i_mdr[31:0]}};
      default: o_wdata = i_mdr;
    endcase
  end

  always_comb begin
    w_nbytes = size_bytes(i_be_size, DATA_W);
    w_ones   = BE_W'((32'd1 << w_nbytes) - 32'd1);
    o_be     = w_ones << i_be_addr;
  end

endmodule

// File: rtl/mdr_handshake.sv
// mdr_handshake: memory data register with legacy direct load plus a request/ready
// handshake to wait-state memory, sub-word sign/zero-extended loads and lane-aligned
// stores with byte enables.
// Ports:
//   clock, clear (async, active high)
//   bus_in, mdatain, mdr_in, read             legacy load path
//   rd_req, wr_req, size, uns, addr_lo        handshaked access request
//   mem_ready                                 memory completion
//   mem_rd, mem_wr, mem_be, mem_wdata         memory request side
//   mdr_out, busy, done, err                  status / contents
// Optional feature: define MDR_TIMEOUT_EN to abort accesses after MAX_WAIT
// wait cycles without mem_ready (err pulse, no done).
module mdr_handshake
  import mdr_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned BE_W     = DATA_W / 8,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic [DATA_W-1:0]        bus_in,
  input  logic [DATA_W-1:0]        mdatain,
  input  logic                     mdr_in,
  input  logic                     read,
  input  logic                     rd_req,
  input  logic                     wr_req,
  input  logic [1:0]               size,
  input  logic                     uns,
  input  logic [$clog2(BE_W)-1:0]  addr_lo,
  input  logic                     mem_ready,
  output logic                     mem_rd,
  output logic                     mem_wr,
  output logic [BE_W-1:0]          mem_be,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [DATA_W-1:0]        mdr_out,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned AW = $clog2(BE_W);

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("MAX_WAIT must be at least 1");
  end

  state_e            r_state;
  logic [DATA_W-1:0] r_mdr;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [AW-1:0]     r_addr;

  logic [1:0]        w_size_eff;
  logic [AW-1:0]     w_mask;
  logic              w_aligned;
  logic [DATA_W-1:0] w_load_data;
  logic [BE_W-1:0]   w_be;

`ifdef MDR_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  logic [WaitW-1:0] r_wait;
  logic             w_timeout;
  assign w_timeout = (r_wait == WaitW'(MAX_WAIT - 1));
`endif

  // A full-width access on a 32-bit register is just a word access.
  assign w_size_eff = (DATA_W == 32 && size == SZ_FULL) ? SZ_WORD : size;
  assign w_mask     = AW'(size_bytes(w_size_eff, DATA_W) - 1);
  assign w_aligned  = ((addr_lo & w_mask) == '0);

  mdr_lane_align #(
    .DATA_W (DATA_W),
    .BE_W   (BE_W),
    .AW     (AW)
  ) u_lane_align (
    .i_size      (r_size),
    .i_uns       (r_uns),
    .i_addr      (r_addr),
    .i_mdatain   (mdatain),
    .i_mdr       (r_mdr),
    .i_be_size   (w_size_eff),
    .i_be_addr   (addr_lo),
    .o_load_data (w_load_data),
    .o_wdata     (mem_wdata),
    .o_be        (w_be)
  );

  assign mdr_out = r_mdr;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= StIdle;
      r_mdr   <= '0;
      r_size  <= SZ_BYTE;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      mem_be  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
`ifdef MDR_TIMEOUT_EN
      r_wait  <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (rd_req || wr_req) begin
            if (!w_aligned) begin
              err <= 1'b1;
            end else begin
              r_size <= w_size_eff;
              r_uns  <= uns;
              r_addr <= addr_lo;
              mem_be <= w_be;
              busy   <= 1'b1;
`ifdef MDR_TIMEOUT_EN
              r_wait <= '0;
`endif
              // Read wins over a simultaneous write; the write is dropped.
              if (rd_req) begin
                r_state <= StRdWait;
                mem_rd  <= 1'b1;
              end else begin
                r_state <= StWrWait;
                mem_wr  <= 1'b1;
              end
            end
          end else if (mdr_in) begin
            r_mdr <= read ? mdatain : bus_in;
          end
        end
        StRdWait, StWrWait: begin
          if (mem_ready) begin
            if (r_state == StRdWait) begin
              r_mdr <= w_load_data;
            end
            r_state <= StIdle;
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            mem_be  <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
`ifdef MDR_TIMEOUT_EN
          end else if (w_timeout) begin
            r_state <= StIdle;
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            mem_be  <= '0;
            busy    <= 1'b0;
            err     <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
`endif
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mdr_handshake.sv
// tb_mdr_handshake: table-driven directed bench for mdr_handshake (DATA_W=32).
// Each table row is applied for one clock edge and the registered outputs are
// compared #1 after that edge. Clear-mid-access and wait-limit behaviour are
// exercised by hand-written sequences.
module tb_mdr_handshake;

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  logic          clock = 1'b0;
  logic          clear;
  logic [DW-1:0] bus_in, mdatain;
  logic          mdr_in, read, rd_req, wr_req, uns, mem_ready;
  logic [1:0]    size, addr_lo;
  logic          mem_rd, mem_wr, busy, done, err;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_wdata, mdr_out;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  mdr_handshake #(
    .DATA_W   (DW),
    .MAX_WAIT (4)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .bus_in    (bus_in),
    .mdatain   (mdatain),
    .mdr_in    (mdr_in),
    .read      (read),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .size      (size),
    .uns       (uns),
    .addr_lo   (addr_lo),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mdr_out   (mdr_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  typedef struct {
    logic [3:0]  ctl;   // {mdr_in, read, rd_req, wr_req}
    logic [1:0]  sz;
    logic        u;
    logic [1:0]  a;
    logic        rdy;
    logic [31:0] bus;
    logic [31:0] md;
    logic [31:0] e_mdr;
    logic [4:0]  e_flg; // {busy, done, err, mem_rd, mem_wr}
    logic [3:0]  e_be;
    logic        cw;    // compare mem_wdata on this row
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] ctl, input logic [1:0] sz, input logic u,
                              input logic [1:0] a, input logic rdy, input logic [31:0] bus,
                              input logic [31:0] md, input logic [31:0] e_mdr,
                              input logic [4:0] e_flg, input logic [3:0] e_be, input logic cw,
                              input logic [31:0] e_wd);
    vec_t v;
    v.ctl = ctl; v.sz = sz; v.u = u; v.a = a; v.rdy = rdy; v.bus = bus; v.md = md;
    v.e_mdr = e_mdr; v.e_flg = e_flg; v.e_be = e_be; v.cw = cw; v.e_wd = e_wd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    mdr_in = 0; read = 0; rd_req = 0; wr_req = 0; mem_ready = 0;
  endtask

  initial begin
    clear = 1'b1;
    bus_in = '0; mdatain = '0; size = '0; uns = 0; addr_lo = '0;
    idle_inputs();

    //       ctl      sz   u  a   rdy bus           md            e_mdr         flg       be
    vecs.push_back(mk(4'b1100, 2'd0, 0, 2'd0, 0, 32'h0,        32'h87654321, 32'h87654321,
                      5'b00000, 4'b0000, 0, 32'h0));
    vecs.push_back(mk(4'b1000, 2'd0, 0, 2'd0, 0, 32'h1,        32'h87654321, 32'h00000001,
                      5'b00000, 4'b0000, 0, 32'h0));
    vecs.push_back(mk(4'b0000, 2'd0, 0, 2'd0, 1, 32'h0,        32'hDEADBEEF, 32'h00000001,
                      5'b00000, 4'b0000, 0, 32'h0));
    // Signed byte read at offset 2, three wait cycles.
    vecs.push_back(mk(4'b0010, 2'd0, 0, 2'd2, 0, 32'h0,        32'h12F45678, 32'h00000001,
                      5'b10010, 4'b0100, 0, 32'h0));
    vecs.push_back(mk(4'b0000, 2'd0, 0, 2'd2, 0, 32'h0,        32'h12F45678, 32'h00000001,
                      5'b10010, 4'b0100, 0, 32'h0));
    vecs.push_back(mk(4'b0000, 2'd0, 0, 2'd2, 0, 32'h0,        32'h12F45678, 32'h00000001,
                      5'b10010, 4'b0100, 0, 32'h0));
    vecs.push_back(mk(4'b0000, 2'd0, 0, 2'd2, 0, 32'h0,        32'h12F45678, 32'h00000001,
                      5'b10010, 4'b0100, 0, 32'h0));
    vecs.push_back(mk(4'b0000, 2'd0, 0, 2'd2, 1, 32'h0,        32'h12F45678, 32'hFFFFFFF4,
                      5'b01000, 4'b0000, 0, 32'h0));
    vecs.push_back(mk(4'b0000, 2'd0, 0, 2'd0, 0, 32'h0,        32'h0,        32'hFFFFFFF4,
                      5'b00000, 4'b0000, 0, 32'h0));
    // Unsigned half read at offset 2; inputs change while waiting (must be latched).
    vecs.push_back(mk(4'b0010, 2'd1, 1, 2'd2, 1, 32'h0,        32'h80011234, 32'hFFFFFFF4,
                      5'b10010, 4'b1100, 0, 32'h0));
    vecs.push_back(mk(4'b0000, 2'd0, 0, 2'd0, 1, 32'h0,        32'h80011234, 32'h00008001,
                      5'b01000, 4'b0000, 0, 32'h0));
    // size=11 on a 32-bit register acts as word.
    vecs.push_back(mk(4'b0010, 2'd3, 0, 2'd0, 0, 32'h0,        32'hCAFEF00D, 32'h00008001,
                      5'b10010, 4'b1111, 0, 32'h0));
    vecs.push_back(mk(4'b0000, 2'd0, 0, 2'd0, 1, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D,
                      5'b01000, 4'b0000, 0, 32'h0));
    // Misaligned word read and misaligned half write.
    vecs.push_back(mk(4'b0010, 2'd2, 0, 2'd1, 0, 32'h0,        32'h0,        32'hCAFEF00D,
                      5'b00100, 4'b0000, 0, 32'h0));
    vecs.push_back(mk(4'b0000, 2'd0, 0, 2'd0, 0, 32'h0,        32'h0,        32'hCAFEF00D,
                      5'b00000, 4'b0000, 0, 32'h0));
    vecs.push_back(mk(4'b0001, 2'd1, 0, 2'd3, 0, 32'h0,        32'h0,        32'hCAFEF00D,
                      5'b00100, 4'b0000, 0, 32'h0));
    // Half store of 0xBEEF at offset 2.
    vecs.push_back(mk(4'b1000, 2'd0, 0, 2'd0, 0, 32'h0000BEEF, 32'h0,        32'h0000BEEF,
                      5'b00000, 4'b0000, 0, 32'h0));
    vecs.push_back(mk(4'b0001, 2'd1, 0, 2'd2, 0, 32'h0,        32'h0,        32'h0000BEEF,
                      5'b10001, 4'b1100, 1, 32'hBEEFBEEF));
    vecs.push_back(mk(4'b0000, 2'd0, 0, 2'd0, 0, 32'h0,        32'h0,        32'h0000BEEF,
                      5'b10001, 4'b1100, 1, 32'hBEEFBEEF));
    vecs.push_back(mk(4'b0000, 2'd0, 0, 2'd0, 1, 32'h0,        32'h0,        32'h0000BEEF,
                      5'b01000, 4'b0000, 0, 32'h0));
    // Read, write and legacy load together: only the read runs; mdr_in ignored while busy.
    vecs.push_back(mk(4'b1011, 2'd2, 0, 2'd0, 0, 32'h55555555, 32'h11223344, 32'h0000BEEF,
                      5'b10010, 4'b1111, 0, 32'h0));
    vecs.push_back(mk(4'b1000, 2'd2, 0, 2'd0, 1, 32'h55555555, 32'h11223344, 32'h11223344,
                      5'b01000, 4'b0000, 0, 32'h0));
    // Byte store at offset 3.
    vecs.push_back(mk(4'b0001, 2'd0, 0, 2'd3, 0, 32'h0,        32'h0,        32'h11223344,
                      5'b10001, 4'b1000, 1, 32'h44444444));
    vecs.push_back(mk(4'b0000, 2'd0, 0, 2'd0, 1, 32'h0,        32'h0,        32'h11223344,
                      5'b01000, 4'b0000, 0, 32'h0));
    // Unsigned byte at offset 3, signed half at offset 0.
    vecs.push_back(mk(4'b0010, 2'd0, 1, 2'd3, 0, 32'h0,        32'h0,        32'h11223344,
                      5'b10010, 4'b1000, 0, 32'h0));
    vecs.push_back(mk(4'b0000, 2'd0, 0, 2'd0, 1, 32'h0,        32'hF4000000, 32'h000000F4,
                      5'b01000, 4'b0000, 0, 32'h0));
    vecs.push_back(mk(4'b0010, 2'd1, 0, 2'd0, 0, 32'h0,        32'h0,        32'h000000F4,
                      5'b10010, 4'b0011, 0, 32'h0));
    vecs.push_back(mk(4'b0000, 2'd0, 0, 2'd0, 1, 32'h0,        32'h00008001, 32'hFFFF8001,
                      5'b01000, 4'b0000, 0, 32'h0));

    // Reset state.
    #40;
    chk("reset mdr_out", 64'(mdr_out), 64'h0);
    chk("reset flags", 64'({busy, done, err, mem_rd, mem_wr}), 64'h0);
    chk("reset mem_be", 64'(mem_be), 64'h0);
    clear = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      {mdr_in, read, rd_req, wr_req} = vecs[i].ctl;
      size = vecs[i].sz; uns = vecs[i].u; addr_lo = vecs[i].a; mem_ready = vecs[i].rdy;
      bus_in = vecs[i].bus; mdatain = vecs[i].md;
      step();
      chk($sformatf("row%0d mdr_out", i), 64'(mdr_out), 64'(vecs[i].e_mdr));
      chk($sformatf("row%0d busy/done/err/rd/wr", i),
          64'({busy, done, err, mem_rd, mem_wr}), 64'(vecs[i].e_flg));
      chk($sformatf("row%0d mem_be", i), 64'(mem_be), 64'(vecs[i].e_be));
      if (vecs[i].cw) chk($sformatf("row%0d mem_wdata", i), 64'(mem_wdata), 64'(vecs[i].e_wd));
    end
    idle_inputs();

    // Clear in RD_WAIT aborts at once and produces no done.
    rd_req = 1; size = 2'd2; addr_lo = '0; mdatain = 32'hA5A5A5A5;
    step();
    rd_req = 0;
    chk("abort setup mem_rd", 64'(mem_rd), 64'h1);
    clear = 1'b1;
    #1;
    chk("abort mem_rd", 64'(mem_rd), 64'h0);
    chk("abort mdr_out", 64'(mdr_out), 64'h0);
    chk("abort busy", 64'(busy), 64'h0);
    mem_ready = 1;
    step();
    clear = 1'b0;
    step();
    mem_ready = 0;
    chk("abort done", 64'(done), 64'h0);
    chk("abort mdr_out after", 64'(mdr_out), 64'h0);

    // Load a known value, then start a read that memory never answers.
    mdr_in = 1; read = 0; bus_in = 32'h0BADF00D;
    step();
    mdr_in = 0;
    rd_req = 1; size = 2'd2; addr_lo = '0; mdatain = 32'h12345678;
    step();
    rd_req = 0;
`ifdef MDR_TIMEOUT_EN
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("timeout wait%0d busy/err", k), 64'({busy, err}), 64'b10);
    end
    step();
    chk("timeout flags", 64'({busy, done, err, mem_rd, mem_wr}), 64'b00100);
    chk("timeout mdr_out", 64'(mdr_out), 64'h0BADF00D);
    step();
    chk("timeout err pulse", 64'(err), 64'h0);
`else
    for (int k = 0; k < 20; k++) step();
    chk("no timeout flags", 64'({busy, done, err, mem_rd, mem_wr}), 64'b10010);
    mem_ready = 1;
    step();
    mem_ready = 0;
    chk("late ready done", 64'(done), 64'h1);
    chk("late ready mdr_out", 64'(mdr_out), 64'h12345678);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
